vmask_accum: RTL and testbench
==============================

Name: vmask_accum

Overview:
- Downstream of the vector mask-compare stage.
- Collects the partial mask words that stage emits per beat (already shifted into position, each with a bit-enable) and OR-merges them into one 64-bit mask destination word per destination address.
- Issues exactly one full-width write to the vector register file write port per completed mask register chunk.
- Completes the multi-beat mask writeback so the compare stage never needs to hold state across beats.

Parameters:
- DATA_WIDTH, 64, width of mask word and bit-enable.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width of the write port.
- ADDR_WIDTH, 32, destination address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- in_valid  input  1  partial mask beat present
- in_addr  input  ADDR_WIDTH  destination address of the beat
- in_mask  input  DATA_WIDTH  positioned mask bits
- in_en  input  DATA_WIDTH  which bit positions of in_mask are meaningful
- in_last  input  1  final beat of the instruction
- in_ready  output  1  block can accept a beat this cycle
- out_valid  output  1  write strobe (single-cycle pulse)
- out_addr  output  ADDR_WIDTH  write address
- out_vec  output  DATA_WIDTH  merged mask word
- out_be  output  BE_WIDTH  byte enables
- out_bits  output  DATA_WIDTH  merged bit-enable; for verification and debug

Behaviour:
- State
  - Accumulator: acc_act, acc_addr, acc_vec, acc_en.
  - One-entry hold buffer: hold_v, hold_addr, hold_vec, hold_en.
  - Registered outputs out_*.
- Reset (synchronous, any cycle, including mid-accumulation)
  - All state and outputs go to 0.
  - in_ready=1.
  - Partial words are discarded and no out_valid is generated.
- Handshake
  - Beat accepted when in_valid && in_ready.
  - in_ready = !hold_v (combinational from register).
  - Beats presented while in_ready=0 are ignored; upstream must hold issue.
- Merge rule, per bit
  - merged_vec = (acc_vec & ~in_en) | (in_mask & in_en).
  - merged_en = acc_en | in_en.
  - Later beat wins on overlap.
  - Bits never enabled stay 0 in out_vec.
- Accept rules (N = acceptance cycle)
  - Idle (acc_act=0): load acc from the beat; acc_act=1.
  - Active, in_addr==acc_addr: merge into acc.
  - Active, in_addr!=acc_addr: emit old acc at N+1, then treat the beat as a load into the freed acc.
- Word completion
  - A word is complete when, after load/merge, in_last=1 or merged_en is all ones (auto-flush).
  - Completed word is emitted at N+1; acc_act=0.
- Simultaneous events
  - Address mismatch plus new word completing in the same beat: old word emitted at N+1; new word goes to hold buffer (hold_v=1, in_ready=0 during N+1); hold emitted at N+2; hold_v clears at N+2.
  - Only this case fills the hold buffer.
- Emit behaviour
  - Emit drives out_valid=1 for exactly one cycle with out_addr, out_vec, out_en-derived out_bits.
  - out_be[k] = |out_bits[8k+7:8k].
  - out_valid=0 on non-emit cycles.
  - out_vec/out_addr/out_be keep their last value when out_valid=0.
- Latency: accepted completing beat to out_valid is 1 cycle (2 cycles for the hold case).
- in_valid with in_en=0: beat accepted; address/last rules still apply; an all-zero-enable word emits with out_be=0.
- Back-to-back completing beats at different addresses every cycle: one emit per cycle, no hold used except as above.

Test Plan:
- Single-beat completion: reset, beat addr=0x40, mask=0x0F, en=0xFF, last=1 -> out_valid at +1, out_vec=0x0F, out_be=0x01, out_addr=0x40, then out_valid=0.
- 8-beat accumulate: beat i sets en=0xFF<<8i, mask=0xA5<<8i, same addr, last on beat 7 -> one write, out_vec=0xA5A5A5A5A5A5A5A5, out_be=0xFF; no earlier out_valid.
- Auto-flush: two beats en=0x00000000FFFFFFFF and 0xFFFFFFFF00000000, last=0 -> write after second beat, out_be=0xFF, acc idle afterwards.
- Overlap override: beat1 en=0xFF mask=0xFF, beat2 en=0x0F mask=0x00 last -> out_vec=0xF0.
- Address change with last: acc at addr 0x10 (en=0xFF, mask=0x3C), next beat addr 0x18, en=0xFF00, mask=0x1100, last=1 -> addr 0x10 write, vec 0x3C at N+1; in_ready=0 at N+1; addr 0x18 write, vec 0x1100, be=0x02 at N+2.
- Reset mid-operation: 3 partial beats then rst for 1 cycle, then a last beat addr 0x20 en=0x1 mask=0x1 -> only one write, out_vec=0x1; no stale bits; no out_valid during or after reset until that beat.

Source files
------------

// File: rtl/vmask_accum_if.sv
// vmask_accum_if
//   Bundles the partial-mask beat input and the register-file write port
//   of the mask accumulator.
//   master : upstream/testbench side. It drives in_valid, in_addr, in_mask,
//            in_en and in_last, and it observes in_ready and out_*.
//   slave  : accumulator side. It observes the beat and drives in_ready,
//            out_valid, out_addr, out_vec, out_be and out_bits.
interface vmask_accum_if #(
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_mask;
    logic [DATA_WIDTH-1:0] in_en;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_vec;
    logic [BE_WIDTH-1:0]   out_be;
    logic [DATA_WIDTH-1:0] out_bits;

    modport master (
        output in_valid, in_addr, in_mask, in_en, in_last,
        input  in_ready, out_valid, out_addr, out_vec, out_be, out_bits
    );

    modport slave (
        input  in_valid, in_addr, in_mask, in_en, in_last,
        output in_ready, out_valid, out_addr, out_vec, out_be, out_bits
    );
endinterface

// File: rtl/vmask_accum.sv
// vmask_accum
//   Merges positioned partial mask beats into one mask word per destination
//   address. It issues a single full-width register-file write for each
//   completed word.
//   Ports:
//     clk : clock
//     rst : synchronous, active-high reset
//     bus : vmask_accum_if.slave. It carries the beat inputs (in_*), the
//           in_ready back-pressure and the registered write port (out_*).
module vmask_accum #(
    parameter int DATA_WIDTH = 64,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    vmask_accum_if.slave  bus
);

    // A byte lane is enabled when any bit in that lane was enabled.
    function automatic logic [BE_WIDTH-1:0] be_of(input logic [DATA_WIDTH-1:0] bits);
        logic [BE_WIDTH-1:0] be;
        be = '0;
        for (int k = 0; k < BE_WIDTH; k++) begin
            be[k] = |bits[8*k +: 8];
        end
        return be;
    endfunction

    logic                  acc_act_r,  acc_act_s;
    logic [ADDR_WIDTH-1:0] acc_addr_r, acc_addr_s;
    logic [DATA_WIDTH-1:0] acc_vec_r,  acc_vec_s;
    logic [DATA_WIDTH-1:0] acc_en_r,   acc_en_s;
    logic                  hold_v_r,    hold_v_s;
    logic [ADDR_WIDTH-1:0] hold_addr_r, hold_addr_s;
    logic [DATA_WIDTH-1:0] hold_vec_r,  hold_vec_s;
    logic [DATA_WIDTH-1:0] hold_en_r,   hold_en_s;
    logic                  out_valid_r, out_valid_s;
    logic [ADDR_WIDTH-1:0] out_addr_r,  out_addr_s;
    logic [DATA_WIDTH-1:0] out_vec_r,   out_vec_s;
    logic [BE_WIDTH-1:0]   out_be_r,    out_be_s;
    logic [DATA_WIDTH-1:0] out_bits_r,  out_bits_s;

    logic                  accept_s;
    logic                  same_s;
    logic                  mismatch_s;
    logic                  complete_s;
    logic [DATA_WIDTH-1:0] base_vec_s;
    logic [DATA_WIDTH-1:0] base_en_s;
    logic [DATA_WIDTH-1:0] merged_vec_s;
    logic [DATA_WIDTH-1:0] merged_en_s;

    assign bus.in_ready  = !hold_v_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.out_vec   = out_vec_r;
    assign bus.out_be    = out_be_r;
    assign bus.out_bits  = out_bits_r;

    // Merge datapath: a beat for a new address merges against an empty word.
    always_comb begin
        accept_s   = bus.in_valid && !hold_v_r;
        same_s     = acc_act_r && (bus.in_addr == acc_addr_r);
        mismatch_s = acc_act_r && !same_s;
        if (same_s) begin
            base_vec_s = acc_vec_r;
            base_en_s  = acc_en_r;
        end else begin
            base_vec_s = '0;
            base_en_s  = '0;
        end
        merged_vec_s = (base_vec_s & ~bus.in_en) | (bus.in_mask & bus.in_en);
        merged_en_s  = base_en_s | bus.in_en;
        complete_s   = bus.in_last || (&merged_en_s);
    end

    // Next-state and emit selection for the accumulator, hold buffer and write port.
    always_comb begin
        acc_act_s   = acc_act_r;
        acc_addr_s  = acc_addr_r;
        acc_vec_s   = acc_vec_r;
        acc_en_s    = acc_en_r;
        hold_v_s    = hold_v_r;
        hold_addr_s = hold_addr_r;
        hold_vec_s  = hold_vec_r;
        hold_en_s   = hold_en_r;
        out_valid_s = 1'b0;
        out_addr_s  = out_addr_r;
        out_vec_s   = out_vec_r;
        out_be_s    = out_be_r;
        out_bits_s  = out_bits_r;

        if (hold_v_r) begin
            // in_ready is low, so no beat competes with draining the hold buffer.
            out_valid_s = 1'b1;
            out_addr_s  = hold_addr_r;
            out_vec_s   = hold_vec_r;
            out_bits_s  = hold_en_r;
            out_be_s    = be_of(hold_en_r);
            hold_v_s    = 1'b0;
        end else if (accept_s) begin
            if (mismatch_s) begin
                // The old word takes this cycle's write slot.
                out_valid_s = 1'b1;
                out_addr_s  = acc_addr_r;
                out_vec_s   = acc_vec_r;
                out_bits_s  = acc_en_r;
                out_be_s    = be_of(acc_en_r);
                if (complete_s) begin
                    // The new word is also complete, so it waits one cycle in the hold buffer.
                    hold_v_s    = 1'b1;
                    hold_addr_s = bus.in_addr;
                    hold_vec_s  = merged_vec_s;
                    hold_en_s   = merged_en_s;
                    acc_act_s   = 1'b0;
                end else begin
                    acc_act_s  = 1'b1;
                    acc_addr_s = bus.in_addr;
                    acc_vec_s  = merged_vec_s;
                    acc_en_s   = merged_en_s;
                end
            end else if (complete_s) begin
                out_valid_s = 1'b1;
                out_addr_s  = bus.in_addr;
                out_vec_s   = merged_vec_s;
                out_bits_s  = merged_en_s;
                out_be_s    = be_of(merged_en_s);
                acc_act_s   = 1'b0;
            end else begin
                acc_act_s  = 1'b1;
                acc_addr_s = bus.in_addr;
                acc_vec_s  = merged_vec_s;
                acc_en_s   = merged_en_s;
            end
        end else begin
            out_valid_s = 1'b0;
        end
    end

    // State register with synchronous reset that discards partial words.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_act_r   <= 1'b0;
            acc_addr_r  <= '0;
            acc_vec_r   <= '0;
            acc_en_r    <= '0;
            hold_v_r    <= 1'b0;
            hold_addr_r <= '0;
            hold_vec_r  <= '0;
            hold_en_r   <= '0;
            out_valid_r <= 1'b0;
            out_addr_r  <= '0;
            out_vec_r   <= '0;
            out_be_r    <= '0;
            out_bits_r  <= '0;
        end else begin
            acc_act_r   <= acc_act_s;
            acc_addr_r  <= acc_addr_s;
            acc_vec_r   <= acc_vec_s;
            acc_en_r    <= acc_en_s;
            hold_v_r    <= hold_v_s;
            hold_addr_r <= hold_addr_s;
            hold_vec_r  <= hold_vec_s;
            hold_en_r   <= hold_en_s;
            out_valid_r <= out_valid_s;
            out_addr_r  <= out_addr_s;
            out_vec_r   <= out_vec_s;
            out_be_r    <= out_be_s;
            out_bits_r  <= out_bits_s;
        end
    end

endmodule

// File: tb/tb_vmask_accum.sv
// tb_vmask_accum
//   Self-checking bench for vmask_accum. Directed scenarios are followed by
//   randomized beats. A cycle-level reference model tracks the open word,
//   the pending second write and the expected write-port contents.
module tb_vmask_accum;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vmask_accum_if #(.DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    vmask_accum #(.DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_known = 1'b0;
    bit          m_act = 1'b0;
    bit          m_hold = 1'b0;
    logic [31:0] m_addr, h_addr;
    logic [63:0] m_vec, m_en, h_vec, h_en;
    bit          e_valid;
    logic [31:0] e_addr;
    logic [63:0] e_vec, e_bits;

    function automatic logic [7:0] be_ref(input logic [63:0] bits);
        logic [7:0] be;
        logic [63:0] t;
        be = 8'h00;
        t = bits;
        for (int k = 0; k < 8; k++) begin
            if ((t & 64'hFF) != 64'h0) be[k] = 1'b1;
            t = t >> 8;
        end
        return be;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic emit(input logic [31:0] a, input logic [63:0] v, input logic [63:0] e);
        e_valid = 1'b1;
        e_addr  = a;
        e_vec   = v;
        e_bits  = e;
    endtask

    // Apply one cycle of stimulus. Advance the model and check every output.
    task automatic cycle(input bit r, input bit v, input logic [31:0] a,
                         input logic [63:0] m, input logic [63:0] e, input bit l);
        bit          acc;
        bit          same;
        logic [63:0] nv, ne;
        rst         = r;
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_mask  = m;
        bus.in_en    = e;
        bus.in_last  = l;
        if (m_known) chk("in_ready", {63'b0, bus.in_ready}, {63'b0, !m_hold});
        acc = v && !m_hold;
        @(posedge clk);
        #1;
        if (r) begin
            m_known = 1'b1;
            m_act = 1'b0; m_hold = 1'b0;
            e_valid = 1'b0; e_addr = 32'h0; e_vec = 64'h0; e_bits = 64'h0;
        end else begin
            e_valid = 1'b0;
            if (m_hold) begin
                emit(h_addr, h_vec, h_en);
                m_hold = 1'b0;
            end else if (acc) begin
                same = m_act && (a == m_addr);
                if (m_act && !same) begin
                    emit(m_addr, m_vec, m_en);
                    m_act = 1'b0;
                end
                nv = same ? m_vec : 64'h0;
                ne = same ? m_en  : 64'h0;
                nv = (nv & ~e) | (m & e);
                ne = ne | e;
                if (l || ne == {64{1'b1}}) begin
                    if (e_valid) begin
                        m_hold = 1'b1; h_addr = a; h_vec = nv; h_en = ne;
                    end else begin
                        emit(a, nv, ne);
                    end
                    m_act = 1'b0;
                end else begin
                    m_act = 1'b1; m_addr = a; m_vec = nv; m_en = ne;
                end
            end
        end
        if (m_known) begin
            chk("out_valid", {63'b0, bus.out_valid}, {63'b0, e_valid});
            chk("out_addr",  {32'b0, bus.out_addr},  {32'b0, e_addr});
            chk("out_vec",   bus.out_vec,  e_vec);
            chk("out_bits",  bus.out_bits, e_bits);
            chk("out_be",    {56'b0, bus.out_be}, {56'b0, be_ref(e_bits)});
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b0);
    endtask

    initial begin
        logic [63:0] rm, re;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_mask = '0; bus.in_en = '0; bus.in_last = 1'b0;

        // Reset
        cycle(1'b1, 1'b0, 32'h0, 64'h0, 64'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 64'h0, 64'h0, 1'b0);
        chk("reset_ready", {63'b0, bus.in_ready}, 64'h1);
        chk("reset_valid", {63'b0, bus.out_valid}, 64'h0);

        // Single-beat completion
        cycle(1'b0, 1'b1, 32'h40, 64'h0F, 64'hFF, 1'b1);
        chk("t1_valid", {63'b0, bus.out_valid}, 64'h1);
        chk("t1_vec", bus.out_vec, 64'h0F);
        chk("t1_be", {56'b0, bus.out_be}, 64'h01);
        chk("t1_addr", {32'b0, bus.out_addr}, 64'h40);
        idle();
        chk("t1_drop", {63'b0, bus.out_valid}, 64'h0);

        // 8-beat accumulate
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 32'h80, 64'hA5 << (8 * i), 64'hFF << (8 * i), i == 7);
        end
        chk("t2_vec", bus.out_vec, 64'hA5A5A5A5A5A5A5A5);
        chk("t2_be", {56'b0, bus.out_be}, 64'hFF);
        idle();

        // Auto-flush on a fully enabled word
        cycle(1'b0, 1'b1, 32'h100, 64'h12345678, 64'h00000000FFFFFFFF, 1'b0);
        chk("t3_noearly", {63'b0, bus.out_valid}, 64'h0);
        cycle(1'b0, 1'b1, 32'h100, 64'h9ABCDEF000000000, 64'hFFFFFFFF00000000, 1'b0);
        chk("t3_vec", bus.out_vec, 64'h9ABCDEF012345678);
        chk("t3_be", {56'b0, bus.out_be}, 64'hFF);
        idle();

        // Later beat wins on overlap
        cycle(1'b0, 1'b1, 32'h140, 64'hFF, 64'hFF, 1'b0);
        cycle(1'b0, 1'b1, 32'h140, 64'h00, 64'h0F, 1'b1);
        chk("t4_vec", bus.out_vec, 64'hF0);
        idle();

        // Address change with last: second word goes through the hold buffer
        cycle(1'b0, 1'b1, 32'h10, 64'h3C, 64'hFF, 1'b0);
        cycle(1'b0, 1'b1, 32'h18, 64'h1100, 64'hFF00, 1'b1);
        chk("t5_addr_a", {32'b0, bus.out_addr}, 64'h10);
        chk("t5_vec_a", bus.out_vec, 64'h3C);
        chk("t5_busy", {63'b0, bus.in_ready}, 64'h0);
        // This beat arrives while in_ready is low and must be ignored.
        cycle(1'b0, 1'b1, 32'h30, 64'hFF, 64'hFF, 1'b1);
        chk("t5_addr_b", {32'b0, bus.out_addr}, 64'h18);
        chk("t5_vec_b", bus.out_vec, 64'h1100);
        chk("t5_be_b", {56'b0, bus.out_be}, 64'h02);
        idle();
        chk("t5_quiet", {63'b0, bus.out_valid}, 64'h0);

        // Reset mid-accumulation discards the partial word
        cycle(1'b0, 1'b1, 32'h20, 64'hF0, 64'hF0, 1'b0);
        cycle(1'b0, 1'b1, 32'h20, 64'hF00, 64'hF00, 1'b0);
        cycle(1'b0, 1'b1, 32'h20, 64'hF000, 64'hF000, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 64'h0, 64'h0, 1'b0);
        chk("t6_rst_valid", {63'b0, bus.out_valid}, 64'h0);
        idle();
        cycle(1'b0, 1'b1, 32'h20, 64'h1, 64'h1, 1'b1);
        chk("t6_vec", bus.out_vec, 64'h1);
        chk("t6_be", {56'b0, bus.out_be}, 64'h01);
        idle();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            rm = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: re = {$urandom, $urandom};
                1: re = 64'hFF << (8 * $urandom_range(0, 7));
                2: re = {64{1'b1}};
                3: re = 64'h0;
                default: re = ($urandom_range(0, 1) == 0) ? 64'h00000000FFFFFFFF : 64'hFFFFFFFF00000000;
            endcase
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  32'($urandom_range(0, 2) * 8), rm, re, $urandom_range(0, 3) == 0);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
